// File: rtl/alu_result_streamer_pkg.sv
// ---------------------------------------------------------------------------
// alu_result_streamer_pkg
// Shared definitions for the ALU result output stage.
//   - Default bus width, maximum beats per result and FIFO depth.
//   - FSM state encoding of the streamer.
//   - FIFO entry layout (result data plus beat count minus one) for the
//     default configuration.
// The top module re-declares the size parameters so it can be overridden per
// instance. The FIFO stores entries as flat vectors so it follows whatever
// sizes the instance uses.
// ---------------------------------------------------------------------------
package alu_result_streamer_pkg;

    localparam int RESULT_BUS_WIDTH = 16;
    localparam int MAX_BEATS        = 4;
    localparam int FIFO_DEPTH       = 4;
    localparam int RESULT_WIDTH     = RESULT_BUS_WIDTH * MAX_BEATS;
    localparam int BEAT_CNT_WIDTH   = $clog2(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } streamer_state_t;

    typedef struct packed {
        logic [RESULT_WIDTH-1:0]   data;
        logic [BEAT_CNT_WIDTH-1:0] beats_m1;
    } fifo_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
// Synchronous FIFO holding pending ALU results. It has a synchronous clear and
// a level output, and the read data is shown from the head without a read
// delay.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   clear       drop every entry (pointers and level return to zero)
//   push        write push_data (ignored when full; there is no pass-through)
//   push_data   entry to write
//   pop         retire the head entry (ignored when empty)
//   pop_data    current head entry
//   level       number of stored entries, 0..DEPTH
//   empty/full  derived from level
// ---------------------------------------------------------------------------
module alu_result_fifo
    import alu_result_streamer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == LEVEL_FULL);
    assign do_push  = push && !full && !clear;
    assign do_pop   = pop && !empty && !clear;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; only the pointers and level define which entries
    // are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (PTR_W + 1)'(1);
                2'b01:   level <= level - (PTR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_streamer.sv
// ---------------------------------------------------------------------------
// alu_result_streamer
// Output stage of the multi-cycle ALU. It buffers full-width results and
// sends each one as 1..MAX_BEATS beats, with the least significant chunk
// first, over a valid/ready result bus.
//
// Optional feature: define ALU_OUT_PARITY_EN to add result_par. This output
// is the even parity of result. It is registered with result and held under
// backpressure.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid       core offers a result
//   in_ready       result accepted on in_valid && in_ready (combinational)
//   in_data        full result, beat k at [k*RESULT_BUS_WIDTH +: RESULT_BUS_WIDTH]
//   in_beats_m1    beats in the result minus one
//   flush          discard all pending and in-flight results
//   result_valid   output beat valid
//   result_ready   sink accepts the beat
//   result         beat data
//   result_last    final beat of the current result
//   result_rst     one-cycle marker following a flush
//   fifo_level     buffered results, not counting the one streaming
//   result_par     (ALU_OUT_PARITY_EN only) even parity of result
//
// State | meaning
// ------+-------------------------------------------------------------------
// IDLE  | nothing presented; the next result is loaded when one is available
// STREAM| a result is in the shift register; result_valid is high
// FLUSH | one cycle after a flush; result_rst is high, returns to IDLE
// ---------------------------------------------------------------------------
module alu_result_streamer
    import alu_result_streamer_pkg::*;
#(
    parameter int RESULT_BUS_WIDTH = alu_result_streamer_pkg::RESULT_BUS_WIDTH,
    parameter int MAX_BEATS        = alu_result_streamer_pkg::MAX_BEATS,
    parameter int FIFO_DEPTH       = alu_result_streamer_pkg::FIFO_DEPTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [RESULT_BUS_WIDTH*MAX_BEATS-1:0]   in_data,
    input  logic [$clog2(MAX_BEATS)-1:0]            in_beats_m1,
    input  logic                                    flush,
    output logic                                    result_valid,
    input  logic                                    result_ready,
    output logic [RESULT_BUS_WIDTH-1:0]             result,
    output logic                                    result_last,
    output logic                                    result_rst,
    output logic [$clog2(FIFO_DEPTH):0]             fifo_level
`ifdef ALU_OUT_PARITY_EN
    ,
    output logic                                    result_par
`endif
);

    localparam int RESULT_WIDTH = RESULT_BUS_WIDTH * MAX_BEATS;
    localparam int BEAT_W       = $clog2(MAX_BEATS);
    localparam int ENTRY_W      = RESULT_WIDTH + BEAT_W;
    localparam int BW           = RESULT_BUS_WIDTH;

    streamer_state_t         state;
    logic [RESULT_WIDTH-1:0] shreg;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [BEAT_W-1:0]       beat_nxt;
    logic [BEAT_W-1:0]       cur_beats_m1;

    logic                    handshake;
    logic                    slot_free;
    logic                    push_in;
    logic                    load_from_fifo;
    logic                    load_bypass;
    logic                    load;
    logic                    fifo_push;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [ENTRY_W-1:0]      fifo_head;
    logic [RESULT_WIDTH-1:0] load_data;
    logic [BEAT_W-1:0]       load_beats_m1;
    logic [BW-1:0]           next_beat;

    assign in_ready  = !rst && !fifo_full && !flush;
    assign push_in   = in_valid && in_ready;
    assign handshake = result_valid && result_ready;

    // The output register becomes free on this edge either because nothing
    // is presented or because the last beat is being consumed.
    assign slot_free = (state == IDLE) ||
                       ((state == STREAM) && handshake && result_last);

    // When the FIFO is empty an incoming result goes straight into the shift
    // register. This gives the one-cycle latency from IDLE and avoids a bubble
    // after a last beat. A FIFO that is full never takes this path, because
    // a full FIFO is not empty.
    assign load_from_fifo = slot_free && !flush && !fifo_empty;
    assign load_bypass    = slot_free && !flush && fifo_empty && push_in;
    assign load           = load_from_fifo || load_bypass;
    assign fifo_push      = push_in && !load_bypass;

    assign load_data     = load_from_fifo ? fifo_head[ENTRY_W-1:BEAT_W] : in_data;
    assign load_beats_m1 = load_from_fifo ? fifo_head[BEAT_W-1:0]       : in_beats_m1;
    assign next_beat     = shreg[2*BW-1:BW];
    assign beat_nxt      = beat_cnt + BEAT_W'(1);

    alu_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (fifo_push),
        .push_data ({in_data, in_beats_m1}),
        .pop       (load_from_fifo),
        .pop_data  (fifo_head),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            beat_cnt     <= '0;
            cur_beats_m1 <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            result_last  <= 1'b0;
            result_rst   <= 1'b0;
        end else if (flush) begin
            // A beat that handshakes on this edge still counts as consumed.
            // Nothing else is presented after it.
            state        <= FLUSH;
            shreg        <= '0;
            beat_cnt     <= '0;
            cur_beats_m1 <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            result_last  <= 1'b0;
            result_rst   <= 1'b1;
        end else begin
            result_rst <= 1'b0;
            if (slot_free) begin
                if (load) begin
                    state        <= STREAM;
                    shreg        <= load_data;
                    beat_cnt     <= '0;
                    cur_beats_m1 <= load_beats_m1;
                    result_valid <= 1'b1;
                    result       <= load_data[BW-1:0];
                    result_last  <= (load_beats_m1 == '0);
                end else begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                    result       <= '0;
                    result_last  <= 1'b0;
                end
            end else if (handshake) begin
                shreg       <= shreg >> BW;
                beat_cnt    <= beat_nxt;
                result      <= next_beat;
                result_last <= (beat_nxt == cur_beats_m1);
            end else if (state == FLUSH) begin
                state <= IDLE;
            end
        end
    end

`ifdef ALU_OUT_PARITY_EN
    // Updated with the same conditions as result so the two never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_par <= 1'b0;
        end else if (flush) begin
            result_par <= 1'b0;
        end else if (slot_free) begin
            result_par <= load ? ^load_data[BW-1:0] : 1'b0;
        end else if (handshake) begin
            result_par <= ^next_beat;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_streamer.sv
module tb_alu_result_streamer;

    localparam int BW = 16;
    localparam int MB = 4;
    localparam int FD = 4;
    localparam int RW = BW * MB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_data;
    logic [1:0]    in_beats_m1;
    logic          flush;
    logic          result_valid;
    logic          result_ready;
    logic [BW-1:0] result;
    logic          result_last;
    logic          result_rst;
    logic [2:0]    fifo_level;
`ifdef ALU_OUT_PARITY_EN
    logic          result_par;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        int          m1;
    } res_t;

    res_t        q[$];
    int          fb;
    bit          rst_exp;
    bit          prev_flush;
    bit          hs;
    bit          accept;
    bit          exp_ready;
    int          lvl;
    logic [15:0] beat;

    always #5 clk = ~clk;

    alu_result_streamer #(
        .RESULT_BUS_WIDTH (BW),
        .MAX_BEATS        (MB),
        .FIFO_DEPTH       (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_beats_m1  (in_beats_m1),
        .flush        (flush),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_last  (result_last),
        .result_rst   (result_rst),
        .fifo_level   (fifo_level)
`ifdef ALU_OUT_PARITY_EN
        ,
        .result_par   (result_par)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic l);
        chk({tag, "_valid"}, 64'(result_valid), 64'(v));
        if (v) begin
            chk({tag, "_data"}, 64'(result), 64'(d));
            chk({tag, "_last"}, 64'(result_last), 64'(l));
        end
    endtask

    initial begin
        logic [15:0] t1 [4];
        t1[0] = 16'h1111; t1[1] = 16'h2222; t1[2] = 16'h3333; t1[3] = 16'h4444;

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_beats_m1  = '0;
        flush        = 1'b0;
        result_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_last", 64'(result_last), 64'd0);
        chk("rst_rstmark", 64'(result_rst), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // single 4-beat result, one-cycle latency, one beat per cycle
        step();
        in_valid    = 1'b1;
        in_data     = 64'h4444_3333_2222_1111;
        in_beats_m1 = 2'd3;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_out("t1_beat", 1'b1, t1[k], k == 3);
            step();
        end
        chk("t1_end_valid", 64'(result_valid), 64'd0);

        // back-to-back results without a bubble
        in_valid    = 1'b1;
        in_data     = 64'h0000_0000_0000_00AA;
        in_beats_m1 = 2'd0;
        step();
        in_data     = 64'h0000_0000_00CC_00BB;
        in_beats_m1 = 2'd1;
        chk_out("t2_aa", 1'b1, 16'h00AA, 1'b1);
        step();
        in_valid = 1'b0;
        chk_out("t2_bb", 1'b1, 16'h00BB, 1'b0);
        step();
        chk_out("t2_cc", 1'b1, 16'h00CC, 1'b1);
        step();
        chk("t2_end_valid", 64'(result_valid), 64'd0);

        // fill under backpressure: one streaming plus FIFO_DEPTH buffered
        result_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1'b1;
            in_data     = 64'h0004_0003_0002_0001 + 64'(i) * 64'h0010_0010_0010_0010;
            in_beats_m1 = 2'd3;
            step();
            chk("t3_fill_level", 64'(fifo_level), 64'(i));
        end
        chk_out("t3_held", 1'b1, 16'h0001, 1'b0);
        in_data = 64'hDEAD_DEAD_DEAD_DEAD;
        #1;
        chk("t3_sixth_ready", 64'(in_ready), 64'd0);
        step();
        chk("t3_level_full", 64'(fifo_level), 64'd4);
        chk_out("t3_still_held", 1'b1, 16'h0001, 1'b0);
        flush = 1'b1;
        #1;
        chk("t3_flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t3_flush_rstmark", 64'(result_rst), 64'd1);
        chk("t3_flush_valid", 64'(result_valid), 64'd0);
        chk("t3_flush_level", 64'(fifo_level), 64'd0);
        step();
        chk("t3_after_rstmark", 64'(result_rst), 64'd0);
        result_ready = 1'b1;

        // flush during beat 2 with two results queued
        in_valid    = 1'b1;
        in_data     = 64'hA004_A003_A002_A001;
        in_beats_m1 = 2'd3;
        step();
        chk_out("t4_a0", 1'b1, 16'hA001, 1'b0);
        in_data     = 64'h0000_0000_0000_B001;
        in_beats_m1 = 2'd0;
        step();
        chk_out("t4_a1", 1'b1, 16'hA002, 1'b0);
        chk("t4_level1", 64'(fifo_level), 64'd1);
        in_data = 64'h0000_0000_0000_C001;
        step();
        chk_out("t4_a2", 1'b1, 16'hA003, 1'b0);
        chk("t4_level2", 64'(fifo_level), 64'd2);
        flush   = 1'b1;
        in_data = 64'h0000_0000_0000_E001;
        #1;
        chk("t4_flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_rstmark", 64'(result_rst), 64'd1);
        chk("t4_valid", 64'(result_valid), 64'd0);
        chk("t4_level0", 64'(fifo_level), 64'd0);
        step();
        chk("t4_rstmark_clear", 64'(result_rst), 64'd0);
        chk("t4_idle_valid", 64'(result_valid), 64'd0);
        in_valid    = 1'b1;
        in_data     = 64'h0000_0000_D002_D001;
        in_beats_m1 = 2'd1;
        step();
        in_valid = 1'b0;
        chk_out("t4_d0", 1'b1, 16'hD001, 1'b0);
        step();
        chk_out("t4_d1", 1'b1, 16'hD002, 1'b1);
        step();
        chk("t4_end_valid", 64'(result_valid), 64'd0);

        // asynchronous reset mid-stream
        in_valid    = 1'b1;
        in_data     = 64'hE004_E003_E002_E001;
        in_beats_m1 = 2'd3;
        step();
        in_valid = 1'b0;
        step();
        chk_out("t5_pre", 1'b1, 16'hE002, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_valid", 64'(result_valid), 64'd0);
        chk("t5_result", 64'(result), 64'd0);
        chk("t5_last", 64'(result_last), 64'd0);
        chk("t5_rstmark", 64'(result_rst), 64'd0);
        chk("t5_level", 64'(fifo_level), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("t5_rstmark_edge", 64'(result_rst), 64'd0);
        #2;
        rst = 1'b0;
        step();
        chk("t5_post_valid", 64'(result_valid), 64'd0);
        chk("t5_post_rstmark", 64'(result_rst), 64'd0);
        chk("t5_post_in_ready", 64'(in_ready), 64'd1);

`ifdef ALU_OUT_PARITY_EN
        // parity of individual beats
        in_valid    = 1'b1;
        in_data     = 64'h0000_0000_0003_0007;
        in_beats_m1 = 2'd1;
        step();
        in_valid = 1'b0;
        chk_out("t6_b0", 1'b1, 16'h0007, 1'b0);
        chk("t6_par1", 64'(result_par), 64'd1);
        step();
        chk_out("t6_b1", 1'b1, 16'h0003, 1'b1);
        chk("t6_par0", 64'(result_par), 64'd0);
        step();
        chk("t6_par_idle_valid", 64'(result_valid), 64'd0);
`endif

        // random traffic against a queue-of-results reference model
        q.delete();
        fb         = 0;
        rst_exp    = 1'b0;
        prev_flush = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            lvl = (q.size() > 0) ? q.size() - 1 : 0;
            chk("rnd_valid", 64'(result_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                beat = q[0].data[fb*16 +: 16];
                chk("rnd_data", 64'(result), 64'(beat));
                chk("rnd_last", 64'(result_last), 64'(fb == q[0].m1));
`ifdef ALU_OUT_PARITY_EN
                chk("rnd_par", 64'(result_par), 64'(^beat));
`endif
            end
            chk("rnd_level", 64'(fifo_level), 64'(lvl));
            chk("rnd_rstmark", 64'(result_rst), 64'(rst_exp));

            flush        = prev_flush ? 1'b0 : ($urandom_range(0, 23) == 0);
            in_valid     = prev_flush ? 1'b0 : 1'($urandom_range(0, 1));
            in_data      = {$urandom, $urandom};
            in_beats_m1  = 2'($urandom_range(0, 3));
            result_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = !flush && (lvl < FD);
            chk("rnd_in_ready", 64'(in_ready), 64'(exp_ready));

            if (flush) begin
                q.delete();
                fb      = 0;
                rst_exp = 1'b1;
            end else begin
                rst_exp = 1'b0;
                hs      = (q.size() > 0) && result_ready;
                accept  = in_valid && exp_ready;
                if (hs) begin
                    if (fb == q[0].m1) begin
                        void'(q.pop_front());
                        fb = 0;
                    end else begin
                        fb++;
                    end
                end
                if (accept) begin
                    q.push_back('{data: in_data, m1: int'(in_beats_m1)});
                end
            end
            prev_flush = flush;
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
